// File: rtl/cta_dispatch_pkg.sv
// Shared types for the CTA dispatcher and the host-side launch scheduler.
//   launch_desc_t : one kernel launch descriptor as seen by the dispatcher
//   kls_state_e   : launch scheduler FSM states
package cta_dispatch_pkg;

    typedef struct packed {
        logic [7:0]  kernel_id;
        logic [15:0] grid_x;
        logic [15:0] grid_y;
        logic [15:0] grid_z;
        logic [31:0] arg_ptr;
    } launch_desc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } kls_state_e;

endpackage

// File: rtl/kernel_launch_sched_if.sv
// Host and dispatcher launch handshakes of the kernel launch scheduler.
//   slave  : the scheduler (accepts host descriptors, drives the dispatcher launch)
//   master : the surrounding host + dispatcher
//   host_valid/host_ready/host_desc/host_flush : descriptor enqueue side
//   disp_valid/disp_ready/disp_desc            : dispatcher launch side
interface kernel_launch_sched_if;
    import cta_dispatch_pkg::*;

    logic         host_valid;
    logic         host_ready;
    launch_desc_t host_desc;
    logic         host_flush;
    logic         disp_valid;
    logic         disp_ready;
    launch_desc_t disp_desc;

    modport slave (
        input  host_valid, host_desc, host_flush, disp_ready,
        output host_ready, disp_valid, disp_desc
    );

    modport master (
        output host_valid, host_desc, host_flush, disp_ready,
        input  host_ready, disp_valid, disp_desc
    );

endinterface

// File: rtl/kls_desc_fifo.sv
// Synchronous descriptor FIFO for the launch scheduler.
//   clk, rst_n : clock, async active-low reset
//   push/din   : write (ignored when full)
//   pop/dout   : read; dout is the current head (registered storage, no bypass)
//   flush      : drops all entries this cycle; wins over push and pop
//   count      : entries held; full/empty are registered
module kls_desc_fifo
    import cta_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  launch_desc_t             din,
    input  logic                     pop,
    output launch_desc_t             dout,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    launch_desc_t  mem_q [DEPTH];
    launch_desc_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;  // DEPTH is a power of 2: pointer wraps naturally
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/kernel_launch_sched.sv
// Host-side launch scheduler in front of the single-kernel CTA dispatcher.
// Queues up to QDEPTH descriptors, issues them in order one at a time, reports
// each kernel's retirement with its issue-to-retire runtime, and flags (without
// aborting) an in-flight kernel that reaches WDOG_CYC cycles.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : host enqueue/flush and dispatcher launch handshakes
//   done_valid   : 1-cycle retirement pulse, with done_kid / done_cycles
//   q_count      : queued descriptors (in-flight one excluded)
//   busy         : queue non-empty or kernel in flight
//   wdog_err     : sticky watchdog flag, cleared by wdog_clr
module kernel_launch_sched
    import cta_dispatch_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter int          KID_W    = 8,
    parameter int          CYC_W    = 32,
    parameter int unsigned WDOG_CYC = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    kernel_launch_sched_if.slave    bus,
    output logic                    done_valid,
    output logic [KID_W-1:0]        done_kid,
    output logic [CYC_W-1:0]        done_cycles,
    output logic [$clog2(QDEPTH):0] q_count,
    output logic                    busy,
    output logic                    wdog_err,
    input  logic                    wdog_clr
);
    kls_state_e       state_q, state_d;
    launch_desc_t     cur_q, cur_d;      // in-flight descriptor
    logic [CYC_W-1:0] cnt_q, cnt_d;      // runtime since dispatcher acceptance
    logic             wdog_q, wdog_d;
    logic [CYC_W-1:0] cnt_inc;
    logic             wdog_hit;

    launch_desc_t            fifo_head;
    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(QDEPTH):0] fifo_count;

    // Ready comes from the registered full flag, so a pop in a full cycle
    // never makes room for a push in that same cycle.
    assign bus.host_ready = !fifo_full && !bus.host_flush;
    assign fifo_push      = bus.host_valid && bus.host_ready;

    kls_desc_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (bus.host_desc),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .flush (bus.host_flush),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        fifo_pop   = 1'b0;
        done_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only reachable from RUN via retirement or reset, so a pop here is
                // always at least one cycle after the previous done pulse.
                if (!fifo_empty && !bus.host_flush) begin
                    fifo_pop = 1'b1;
                    cur_d    = fifo_head;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.disp_ready) begin
                    cnt_d   = CYC_W'(1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Dispatcher ready is still stale here; counting continues.
                cnt_d   = cnt_inc;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (bus.disp_ready) begin
                    done_valid = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set wins over clear when both happen in the same cycle.
    assign wdog_hit = (WDOG_CYC != 0) && (state_q == RUN) && (cnt_q == CYC_W'(WDOG_CYC));
    assign wdog_d   = wdog_hit || (wdog_q && !wdog_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            wdog_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.disp_valid = (state_q == ISSUE);
    assign bus.disp_desc  = cur_q;
    assign done_kid       = done_valid ? KID_W'(cur_q.kernel_id) : '0;
    assign done_cycles    = done_valid ? cnt_q : '0;
    assign q_count        = fifo_count;
    assign busy           = (fifo_count != '0) || (state_q != IDLE);
    assign wdog_err       = wdog_q;

endmodule
